// File: rtl/multiplier_pipe_pkg.sv
// Shared datapath widths for the multiply-accumulate pipeline.
// These defaults match the restoring divider's quotient/divisor widths.
package multiplier_pipe_pkg;

   localparam int DEF_WIDTH_MULTIPLICAND = 5;
   localparam int DEF_WIDTH_MULTIPLIER   = 3;

endpackage

// File: rtl/multiplier_cell.sv
// One registered shift-add stage of the multiply-accumulate pipeline.
// It adds multiplier<<K when multiplicand bit K is set, and carries the operands forward.
module multiplier_cell
   import multiplier_pipe_pkg::*;
#(
   parameter int N = DEF_WIDTH_MULTIPLICAND,
   parameter int M = DEF_WIDTH_MULTIPLIER,
   parameter int K = 0
) (
   input  logic           clk,
   input  logic           arst_n,
   input  logic           valid_i,
   input  logic [N+M-1:0] acc_i,
   input  logic [N-1:0]   a_i,
   input  logic [M-1:0]   b_i,
   output logic           valid_o,
   output logic [N+M-1:0] acc_o,
   output logic [N-1:0]   a_o,
   output logic [M-1:0]   b_o
);

   localparam int W = N + M;

   logic [W-1:0] pp;
   logic [W-1:0] acc_d, acc_q;
   logic [N-1:0] a_q;
   logic [M-1:0] b_q;
   logic         valid_q;

   assign pp    = a_i[K] ? ({{N{1'b0}}, b_i} << K) : '0;
   assign acc_d = acc_i + pp;

   // Data only loads on valid so idle X operands never propagate.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         valid_q <= 1'b0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            acc_q <= acc_d;
            a_q   <= a_i;
            b_q   <= b_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign acc_o   = acc_q;
   assign a_o     = a_q;
   assign b_o     = b_q;

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined shift-add multiply-accumulate: product = multiplicand*multiplier + addend.
// One cell per multiplicand bit; result and rdy come from the last cell.
module multiplier_pipe
   import multiplier_pipe_pkg::*;
#(
   parameter int WIDTH_MULTIPLICAND = DEF_WIDTH_MULTIPLICAND,
   parameter int WIDTH_MULTIPLIER   = DEF_WIDTH_MULTIPLIER
) (
   input  logic                                     clk,
   input  logic                                     arst_n,
   input  logic                                     en,
   input  logic [WIDTH_MULTIPLICAND-1:0]            multiplicand,
   input  logic [WIDTH_MULTIPLIER-1:0]              multiplier,
   input  logic [WIDTH_MULTIPLIER-1:0]              addend,
   output logic                                     rdy,
   output logic [WIDTH_MULTIPLICAND+WIDTH_MULTIPLIER-1:0] product
);

   localparam int N = WIDTH_MULTIPLICAND;
   localparam int M = WIDTH_MULTIPLIER;
   localparam int W = N + M;

   logic         valid_s [N];
   logic [W-1:0] acc_s   [N];
   logic [N-1:0] a_s     [N];
   logic [M-1:0] b_s     [N];

   for (genvar k = 0; k < N; k++) begin : g_stage
      if (k == 0) begin : g_head
         multiplier_cell #(.N(N), .M(M), .K(0)) u_cell (
            .clk     (clk),
            .arst_n  (arst_n),
            .valid_i (en),
            .acc_i   ({{N{1'b0}}, addend}),
            .a_i     (multiplicand),
            .b_i     (multiplier),
            .valid_o (valid_s[0]),
            .acc_o   (acc_s[0]),
            .a_o     (a_s[0]),
            .b_o     (b_s[0])
         );
      end else begin : g_body
         multiplier_cell #(.N(N), .M(M), .K(k)) u_cell (
            .clk     (clk),
            .arst_n  (arst_n),
            .valid_i (valid_s[k-1]),
            .acc_i   (acc_s[k-1]),
            .a_i     (a_s[k-1]),
            .b_i     (b_s[k-1]),
            .valid_o (valid_s[k]),
            .acc_o   (acc_s[k]),
            .a_o     (a_s[k]),
            .b_o     (b_s[k])
         );
      end
   end

   assign rdy     = valid_s[N-1];
   assign product = acc_s[N-1];

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed and table-driven checks for multiplier_pipe (N=5, M=3).
// A cycle scoreboard tracks expected rdy timing and the held product value.
module tb_multiplier_pipe;

   localparam int N = 5;
   localparam int M = 3;

   logic         clk = 1'b0;
   logic         arst_n = 1'b0;
   logic         en = 1'b0;
   logic [N-1:0] multiplicand = '0;
   logic [M-1:0] multiplier = '0;
   logic [M-1:0] addend = '0;
   logic         rdy;
   logic [N+M-1:0] product;

   multiplier_pipe #(
      .WIDTH_MULTIPLICAND (N),
      .WIDTH_MULTIPLIER   (M)
   ) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .en           (en),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .rdy          (rdy),
      .product      (product)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   a;
      logic [M-1:0]   b;
      logic [M-1:0]   c;
      logic [N+M-1:0] p;
   } vec_t;

   typedef struct {
      logic [N+M-1:0] p;
      int             due;
   } pend_t;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   pend_t q[$];
   logic [N+M-1:0] last_p = '0;
   logic [N+M-1:0] exp_in = '0;
   vec_t tbl[9];

   task automatic check(input string name, input logic [N+M-1:0] act,
                        input logic [N+M-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      logic er;
      pend_t e;
      if (!arst_n) begin
         q.delete();
         last_p = '0;
      end else if (en) begin
         e.p   = exp_in;
         e.due = cyc + N;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!arst_n) begin
         q.delete();
         last_p = '0;
      end
      er = (q.size() > 0) && (q[0].due == cyc);
      check("rdy", {{(N+M-1){1'b0}}, rdy}, {{(N+M-1){1'b0}}, er});
      if (er) begin
         last_p = q[0].p;
         void'(q.pop_front());
      end
      check("product", product, last_p);
   endtask

   task automatic issue(input logic [N-1:0] a, input logic [M-1:0] b,
                        input logic [M-1:0] c, input logic [N+M-1:0] p);
      en = 1'b1;
      multiplicand = a;
      multiplier = b;
      addend = c;
      exp_in = p;
      step();
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      multiplicand = 'x;
      multiplier = 'x;
      addend = 'x;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      tbl[0] = '{a: 5'd0,  b: 3'd5, c: 3'd3, p: 8'd3};
      tbl[1] = '{a: 5'd1,  b: 3'd0, c: 3'd0, p: 8'd0};
      tbl[2] = '{a: 5'd16, b: 3'd1, c: 3'd0, p: 8'd16};
      tbl[3] = '{a: 5'd21, b: 3'd6, c: 3'd2, p: 8'd128};
      tbl[4] = '{a: 5'd10, b: 3'd3, c: 3'd5, p: 8'd35};
      tbl[5] = '{a: 5'd10, b: 3'd3, c: 3'd5, p: 8'd35};
      tbl[6] = '{a: 5'd31, b: 3'd0, c: 3'd7, p: 8'd7};
      tbl[7] = '{a: 5'd7,  b: 3'd7, c: 3'd0, p: 8'd49};
      tbl[8] = '{a: 5'd31, b: 3'd7, c: 3'd7, p: 8'd224};

      // reset held for 3 cycles, then idle
      arst_n = 1'b0;
      idle(3);
      arst_n = 1'b1;
      idle(6);

      // single op: exact latency and hold afterwards
      issue(5'd31, 3'd7, 3'd7, 8'd224);
      idle(3);
      check("single_early", {7'd0, rdy}, 8'd0);
      idle(1);
      check("single_rdy", {7'd0, rdy}, 8'd1);
      check("single_p", product, 8'd224);
      idle(1);
      check("single_hold", product, 8'd224);
      idle(4);

      // table vectors back-to-back
      for (int i = 0; i < 9; i++) issue(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].p);
      idle(N + 2);

      // first three table entries with gaps
      for (int i = 0; i < 3; i++) begin
         issue(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].p);
         idle(i + 1);
      end
      idle(N + 2);

      // streaming, then random gaps
      for (int i = 0; i < 200; i++) begin
         logic [N-1:0] a;
         logic [M-1:0] b, c;
         a = N'($urandom);
         b = M'($urandom);
         c = M'($urandom);
         issue(a, b, c, (N+M)'(a * b + c));
      end
      for (int i = 0; i < 150; i++) begin
         logic [N-1:0] a;
         logic [M-1:0] b, c;
         a = N'($urandom);
         b = M'($urandom);
         c = M'($urandom);
         if ($urandom_range(1, 0) == 1) issue(a, b, c, (N+M)'(a * b + c));
         else idle(1);
      end
      idle(N + 2);

      // reset mid-flight: in-flight ops discarded
      issue(5'd9, 3'd3, 3'd1, 8'd28);
      issue(5'd12, 3'd5, 3'd2, 8'd62);
      arst_n = 1'b0;
      issue(5'd3, 3'd3, 3'd3, 8'd12);
      idle(1);
      arst_n = 1'b1;
      idle(N + 3);
      check("rst_p_zero", product, 8'd0);
      issue(5'd3, 3'd2, 3'd1, 8'd7);
      idle(N + 1);
      check("post_rst_p", product, 8'd7);

      // round trip with divider results
      for (int d = 0; d < 32; d++) begin
         for (int v = 1; v < 8; v++) begin
            issue(N'(d / v), M'(v), M'(d % v), (N+M)'(d));
         end
      end
      issue(5'd5, 3'd5, 3'd4, 8'd29);
      idle(N + 2);
      check("rt_29", product, 8'd29);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
